data_mem_arbiter: RTL

Arbiter and dump sequencer for the data memory behind the MEM stage. In normal operation it passes the MEM stage's load/store requests straight through to the single-port data memory. On request from the debug unit it takes ownership of the memory, walks every word from address 0 upward and streams each word to the debug unit over a valid/ready handshake. While a dump runs, the pipeline is stalled.

---
 rtl/data_mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: passes MEM-stage loads/stores through to the single-port
// memory, or takes the memory over to stream every word to the debug unit.
module data_mem_arbiter #(
  parameter int NB_ADDR     = 32,
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 7
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_MEM_mem_read,
  input  logic                   i_MEM_mem_write,
  input  logic [NB_ADDR-1:0]     i_MEM_addr,
  input  logic [NB_DATA-1:0]     i_MEM_write_data,
  output logic [NB_DATA-1:0]     o_MEM_read_data,
  output logic                   o_MEM_stall,
  input  logic                   i_DU_dump_start,
  input  logic                   i_DU_ready,
  output logic [NB_DATA-1:0]     o_DU_data,
  output logic                   o_DU_valid,
  output logic                   o_DU_last,
  output logic                   o_DU_busy,
  output logic                   o_DU_done,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0]     o_mem_wdata,
  output logic                   o_mem_we,
  output logic                   o_mem_re,
  input  logic [NB_DATA-1:0]     i_mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    DUMP_RD,
    DUMP_CAP,
    DUMP_SEND,
    DONE
  } state_t;

  state_t                 state;
  logic [NB_MEM_ADDR-1:0] ptr;

  // Byte-lane and out-of-range address bits are deliberately discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_MEM_addr[NB_ADDR-1:NB_MEM_ADDR+2], i_MEM_addr[1:0]};

  assign o_MEM_read_data = i_mem_rdata;

  always_comb begin
    o_mem_addr  = i_MEM_addr[NB_MEM_ADDR+1:2];
    o_mem_wdata = i_MEM_write_data;
    o_mem_we    = i_MEM_mem_write;
    o_mem_re    = i_MEM_mem_read;
    o_MEM_stall = 1'b0;
    if (state != IDLE) begin
      // Memory belongs to the dump; pipeline requests are held off, never written.
      o_mem_addr  = ptr;
      o_mem_we    = 1'b0;
      o_mem_re    = (state == DUMP_RD);
      o_MEM_stall = i_MEM_mem_read | i_MEM_mem_write;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      ptr        <= '0;
      o_DU_data  <= '0;
      o_DU_valid <= 1'b0;
      o_DU_last  <= 1'b0;
      o_DU_busy  <= 1'b0;
      o_DU_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_DU_done <= 1'b0;
          if (i_DU_dump_start) begin
            state     <= DUMP_RD;
            o_DU_busy <= 1'b1;
          end
        end
        DUMP_RD: state <= DUMP_CAP;
        DUMP_CAP: begin
          o_DU_data  <= i_mem_rdata;
          o_DU_valid <= 1'b1;
          o_DU_last  <= &ptr;
          state      <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (i_DU_ready) begin
            o_DU_valid <= 1'b0;
            o_DU_last  <= 1'b0;
            if (o_DU_last) begin
              o_DU_done <= 1'b1;
              state     <= DONE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= DUMP_RD;
            end
          end
        end
        DONE: begin
          o_DU_done <= 1'b0;
          o_DU_busy <= 1'b0;
          ptr       <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
